// File: rtl/mad_frame_deser20_if.sv
// Result-line bundle for the 20-bit frame receiver: serial input plus the
// valid/ready output register and status flags.
interface mad_frame_deser20_if;
    logic        serialport;
    logic [7:0]  coordinate;
    logic [11:0] mad;
    logic        out_valid;
    logic        out_ready;
    logic        frame_err;
    logic        overrun;

    // Line driver / frame consumer side.
    modport master (
        output serialport,
        output out_ready,
        input  coordinate,
        input  mad,
        input  out_valid,
        input  frame_err,
        input  overrun
    );

    // Receiver side.
    modport slave (
        input  serialport,
        input  out_ready,
        output coordinate,
        output mad,
        output out_valid,
        output frame_err,
        output overrun
    );
endinterface

// File: rtl/mad_frame_deser20.sv
// Serial-to-parallel receiver for the {coordinate[7:0], mad[11:0]} result frame,
// presenting each good frame on a one-deep valid/ready output register.
module mad_frame_deser20 #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FRAME_BITS   = 20
) (
    input logic                clk,
    input logic                rst,
    mad_frame_deser20_if.slave bus
);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] Half = CntW'(CLKS_PER_BIT / 2);
    localparam logic [CntW-1:0] Last = CntW'(CLKS_PER_BIT - 1);
    localparam logic [4:0] LastBit = 5'(FRAME_BITS - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e                  state_q;
    logic [CntW-1:0]         cnt_q;
    logic [4:0]              bit_cnt_q;
    logic [FRAME_BITS-1:0]   shreg_q;
    logic [7:0]              coord_q;
    logic [11:0]             mad_q;
    logic                    out_valid_q;
    logic                    frame_err_q;
    logic                    overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            coord_q     <= '0;
            mad_q       <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    bit_cnt_q <= '0;
                    if (!bus.serialport) begin
                        state_q <= StStart;
                        cnt_q   <= CntW'(1);
                    end
                end
                StStart: begin
                    if (cnt_q == Half) begin
                        cnt_q   <= '0;
                        state_q <= bus.serialport ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (cnt_q == Last) begin
                        cnt_q     <= '0;
                        shreg_q   <= {shreg_q[FRAME_BITS-2:0], bus.serialport};
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        if (bit_cnt_q == LastBit) begin
                            state_q <= StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StStop: begin
                    if (cnt_q == Last) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                        if (!bus.serialport) begin
                            frame_err_q <= 1'b1;
                        end else if (!out_valid_q || bus.out_ready) begin
                            // Commit overrides the accept-clear above, so a same-cycle
                            // accept and commit leaves out_valid high with new data.
                            coord_q     <= shreg_q[FRAME_BITS-1 -: 8];
                            mad_q       <= shreg_q[11:0];
                            out_valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.coordinate = coord_q;
    assign bus.mad        = mad_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_mad_frame_deser20.sv
// Directed bench for mad_frame_deser20: drives serial frames bit by bit and checks
// delivered frames, error pulses and the overrun flag against hand-computed values.
module tb_mad_frame_deser20;
    localparam int unsigned CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   valid_cnt = 0;
    int   err_cnt = 0;

    mad_frame_deser20_if bus_if ();

    mad_frame_deser20 #(
        .CLKS_PER_BIT (CPB),
        .FRAME_BITS   (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Counts cycles with out_valid / frame_err high, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && bus_if.out_valid === 1'b1) valid_cnt = valid_cnt + 1;
        if (!rst && bus_if.frame_err === 1'b1) err_cnt = err_cnt + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        bus_if.serialport = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [11:0] m, input logic stop_bit);
        logic [19:0] p;
        p = {c, m};
        drive_bit(1'b0);
        for (int i = 19; i >= 0; i--) drive_bit(p[i]);
        drive_bit(stop_bit);
        bus_if.serialport = 1'b1;
    endtask

    task automatic test_reset();
        int v0;
        rst = 1'b1;
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_if.serialport = i[0];
            @(posedge clk);
        end
        #1;
        checks++; if (bus_if.coordinate !== 8'h00) begin errors++;
            $display("FAIL reset_coord: got %h want 00", bus_if.coordinate); end
        checks++; if (bus_if.mad !== 12'h000) begin errors++;
            $display("FAIL reset_mad: got %h want 000", bus_if.mad); end
        checks++; if (bus_if.out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b want 0", bus_if.out_valid); end
        checks++; if (bus_if.frame_err !== 1'b0) begin errors++;
            $display("FAIL reset_frame_err: got %b want 0", bus_if.frame_err); end
        checks++; if (bus_if.overrun !== 1'b0) begin errors++;
            $display("FAIL reset_overrun: got %b want 0", bus_if.overrun); end
        rst = 1'b0;
        bus_if.serialport = 1'b1;
        v0 = valid_cnt;
        idle(50);
        checks++; if (valid_cnt - v0 !== 0 || bus_if.out_valid !== 1'b0) begin errors++;
            $display("FAIL idle_line: valid cycles %0d want 0", valid_cnt - v0); end
    endtask

    task automatic test_basic_frame();
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'hA5, 12'h3C7, 1'b1);
        idle(4);
        checks++; if (valid_cnt - v0 !== 1) begin errors++;
            $display("FAIL basic_valid_cycles: got %0d want 1", valid_cnt - v0); end
        checks++; if (bus_if.coordinate !== 8'hA5) begin errors++;
            $display("FAIL basic_coord: got %h want a5", bus_if.coordinate); end
        checks++; if (bus_if.mad !== 12'h3C7) begin errors++;
            $display("FAIL basic_mad: got %h want 3c7", bus_if.mad); end
        checks++; if (err_cnt - e0 !== 0) begin errors++;
            $display("FAIL basic_frame_err: got %0d pulses want 0", err_cnt - e0); end
    endtask

    task automatic test_glitch();
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        bus_if.serialport = 1'b0;
        idle(1);
        bus_if.serialport = 1'b1;
        idle(10);
        checks++; if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin errors++;
            $display("FAIL glitch_ignored: valid %0d err %0d want 0 0",
                     valid_cnt - v0, err_cnt - e0); end
        send_frame(8'h01, 12'hFFF, 1'b1);
        idle(4);
        checks++; if (valid_cnt - v0 !== 1) begin errors++;
            $display("FAIL glitch_next_valid: got %0d want 1", valid_cnt - v0); end
        checks++; if (bus_if.coordinate !== 8'h01 || bus_if.mad !== 12'hFFF) begin errors++;
            $display("FAIL glitch_next_data: got %h/%h want 01/fff",
                     bus_if.coordinate, bus_if.mad); end
    endtask

    task automatic test_frame_err();
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h7E, 12'h001, 1'b0);
        idle(8);
        checks++; if (err_cnt - e0 !== 1) begin errors++;
            $display("FAIL ferr_pulse: got %0d cycles want 1", err_cnt - e0); end
        checks++; if (valid_cnt - v0 !== 0) begin errors++;
            $display("FAIL ferr_no_valid: got %0d want 0", valid_cnt - v0); end
        checks++; if (bus_if.coordinate !== 8'h01 || bus_if.mad !== 12'hFFF) begin errors++;
            $display("FAIL ferr_hold: got %h/%h want 01/fff", bus_if.coordinate, bus_if.mad); end
    endtask

    task automatic test_back_to_back();
        bus_if.out_ready = 1'b0;
        send_frame(8'h10, 12'h100, 1'b1);
        send_frame(8'h20, 12'h200, 1'b1);
        idle(4);
        checks++; if (bus_if.out_valid !== 1'b1) begin errors++;
            $display("FAIL b2b_valid_held: got %b want 1", bus_if.out_valid); end
        checks++; if (bus_if.coordinate !== 8'h10 || bus_if.mad !== 12'h100) begin errors++;
            $display("FAIL b2b_data_kept: got %h/%h want 10/100",
                     bus_if.coordinate, bus_if.mad); end
        checks++; if (bus_if.overrun !== 1'b1) begin errors++;
            $display("FAIL b2b_overrun: got %b want 1", bus_if.overrun); end
        bus_if.out_ready = 1'b1;
        idle(1);
        checks++; if (bus_if.out_valid !== 1'b0) begin errors++;
            $display("FAIL b2b_accept: got %b want 0", bus_if.out_valid); end
        checks++; if (bus_if.overrun !== 1'b1) begin errors++;
            $display("FAIL b2b_overrun_sticky: got %b want 1", bus_if.overrun); end
    endtask

    task automatic test_mid_frame_reset();
        logic [19:0] p;
        int v0, e0;
        p = {8'h5A, 12'h5A5};
        drive_bit(1'b0);
        for (int i = 19; i > 10; i--) drive_bit(p[i]);
        bus_if.serialport = p[10];
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        bus_if.serialport = 1'b1;
        idle(10);
        checks++; if (bus_if.out_valid !== 1'b0 || bus_if.overrun !== 1'b0) begin errors++;
            $display("FAIL midrst_flags: valid %b overrun %b want 0 0",
                     bus_if.out_valid, bus_if.overrun); end
        checks++; if (bus_if.coordinate !== 8'h00 || bus_if.mad !== 12'h000) begin errors++;
            $display("FAIL midrst_clear: got %h/%h want 00/000", bus_if.coordinate, bus_if.mad); end
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'hFF, 12'h000, 1'b1);
        idle(4);
        checks++; if (valid_cnt - v0 !== 1) begin errors++;
            $display("FAIL midrst_valid: got %0d want 1", valid_cnt - v0); end
        checks++; if (bus_if.coordinate !== 8'hFF || bus_if.mad !== 12'h000) begin errors++;
            $display("FAIL midrst_data: got %h/%h want ff/000", bus_if.coordinate, bus_if.mad); end
        checks++; if (err_cnt - e0 !== 0 || bus_if.overrun !== 1'b0) begin errors++;
            $display("FAIL midrst_no_err: err %0d overrun %b want 0 0",
                     err_cnt - e0, bus_if.overrun); end
    endtask

    initial begin
        bus_if.serialport = 1'b1;
        bus_if.out_ready  = 1'b1;
        test_reset();
        test_basic_frame();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_mid_frame_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
